// File: rtl/lsu_ctrl_pkg.sv
// Shared types and encodings for the MEM-stage load/store unit:
// funct3 codes, RAM size codes, exception causes and FSM states.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_HOLD    = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b011;
  localparam logic [2:0] SZ_HU = 3'b100;

  localparam logic [1:0] EXC_NONE   = 2'b00;
  localparam logic [1:0] EXC_LD_MIS = 2'b01;
  localparam logic [1:0] EXC_ST_MIS = 2'b10;
  localparam logic [1:0] EXC_ILL    = 2'b11;

  function automatic logic [1:0] lsu_cause(input logic legal, input logic we);
    if (!legal) begin
      return EXC_ILL;
    end else begin
      return we ? EXC_ST_MIS : EXC_LD_MIS;
    end
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bus bundle around the load/store unit: EX/MEM request, data RAM port,
// writeback result and exception report. slave = LSU side, master = environment.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [2:0]        req_funct3_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;
  logic [RD_W-1:0]   req_rd_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [2:0]        mem_size_o;
  logic [31:0]       mem_data_i;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [RD_W-1:0]   wb_rd_o;
  logic [31:0]       wb_data_o;
  logic              exc_valid_o;
  logic [1:0]        exc_cause_o;
  logic [ADDR_W-1:0] exc_addr_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    input  mem_data_i, wb_ready_i,
    output req_ready_o, mem_addr_o, mem_data_o, mem_we_o, mem_re_o, mem_size_o,
    output wb_valid_o, wb_rd_o, wb_data_o, exc_valid_o, exc_cause_o, exc_addr_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    output mem_data_i, wb_ready_i,
    input  req_ready_o, mem_addr_o, mem_data_o, mem_we_o, mem_re_o, mem_size_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, exc_valid_o, exc_cause_o, exc_addr_o
  );
endinterface

// File: rtl/lsu_align_chk.sv
// funct3 -> RAM size decode, legality and alignment handling.
// LSU_MISALIGN_TRAP_EN: misaligned accesses fault; otherwise the address is force-aligned.
module lsu_align_chk
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [2:0]        o_size,
  output logic              o_fault,
  output logic [1:0]        o_cause,
  output logic [ADDR_W-1:0] o_addr
);

  logic w_legal;
  logic w_half;
  logic w_word;

  always_comb begin
    w_legal = 1'b1;
    o_size  = SZ_B;
    w_half  = 1'b0;
    w_word  = 1'b0;
    if (i_we) begin
      case (i_funct3)
        F3_B:    o_size = SZ_B;
        F3_H:    begin o_size = SZ_H; w_half = 1'b1; end
        F3_W:    begin o_size = SZ_W; w_word = 1'b1; end
        default: w_legal = 1'b0;
      endcase
    end else begin
      case (i_funct3)
        F3_B:    o_size = SZ_B;
        F3_H:    begin o_size = SZ_H;  w_half = 1'b1; end
        F3_W:    begin o_size = SZ_W;  w_word = 1'b1; end
        F3_BU:   o_size = SZ_BU;
        F3_HU:   begin o_size = SZ_HU; w_half = 1'b1; end
        default: w_legal = 1'b0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;

  always_comb begin
    w_misalign = (w_half & i_addr[0]) | (w_word & (i_addr[1:0] != 2'b00));
    o_addr     = i_addr;
    o_fault    = ~w_legal | w_misalign;
    o_cause    = lsu_cause(w_legal, i_we);
  end
`else
  // Without the trap, low address bits are simply dropped to natural alignment.
  always_comb begin
    o_addr = i_addr;
    if (w_word) begin
      o_addr[1:0] = 2'b00;
    end else if (w_half) begin
      o_addr[0] = 1'b0;
    end else begin
      o_addr = i_addr;
    end
    o_fault = ~w_legal;
    o_cause = EXC_ILL;
  end
`endif

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store unit in front of a 1-cycle synchronous data RAM.
// Optional build macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses).
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input logic     clk,
  input logic     rst,
  lsu_ctrl_if.slave bus
);
  import lsu_ctrl_pkg::*;

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic [31:0]       r_skid;
  logic [RD_W-1:0]   r_wb_rd;
  logic              r_exc_valid;
  logic [1:0]        r_exc_cause;
  logic [ADDR_W-1:0] r_exc_addr;

  logic [2:0]        w_size;
  logic              w_fault;
  logic [1:0]        w_cause;
  logic [ADDR_W-1:0] w_addr;
  logic              w_ready;
  logic              w_accept;
  logic              w_issue;
  logic              w_load;
  logic              w_capture;

  lsu_align_chk #(.ADDR_W(ADDR_W)) u_align (
    .i_we    (bus.req_we_i),
    .i_funct3(bus.req_funct3_i),
    .i_addr  (bus.req_addr_i),
    .o_size  (w_size),
    .o_fault (w_fault),
    .o_cause (w_cause),
    .o_addr  (w_addr)
  );

  always_comb begin
    w_ready   = 1'b0;
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE:    w_ready = 1'b1;
      ST_RD_WAIT: w_ready = bus.wb_ready_i;
      ST_HOLD:    w_ready = 1'b0;
      default:    w_ready = 1'b0;
    endcase
    w_accept = bus.req_valid_i & w_ready;
    w_issue  = w_accept & ~w_fault;
    w_load   = w_issue & ~bus.req_we_i;
    case (r_state)
      ST_IDLE: w_next = w_load ? ST_RD_WAIT : ST_IDLE;
      ST_RD_WAIT: begin
        // A stalled writeback parks the one-shot RAM data in the skid register.
        if (bus.wb_ready_i) begin
          w_next = w_load ? ST_RD_WAIT : ST_IDLE;
        end else begin
          w_next    = ST_HOLD;
          w_capture = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.wb_ready_i) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_HOLD;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_skid      <= 32'd0;
      r_wb_rd     <= {RD_W{1'b0}};
      r_exc_valid <= 1'b0;
      r_exc_cause <= EXC_NONE;
      r_exc_addr  <= {ADDR_W{1'b0}};
    end else begin
      r_state     <= w_next;
      r_exc_valid <= w_accept & w_fault;
      if (w_capture) begin
        r_skid <= bus.mem_data_i;
      end
      if (w_load) begin
        r_wb_rd <= bus.req_rd_i;
      end
      if (w_accept & w_fault) begin
        r_exc_cause <= w_cause;
        r_exc_addr  <= bus.req_addr_i;
      end
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.mem_we_o    = w_issue & bus.req_we_i;
  assign bus.mem_re_o    = w_load;
  assign bus.mem_addr_o  = w_issue ? w_addr : {ADDR_W{1'b0}};
  assign bus.mem_size_o  = w_issue ? w_size : 3'b000;
  assign bus.mem_data_o  = (w_issue & bus.req_we_i) ? bus.req_wdata_i : 32'd0;

  assign bus.wb_valid_o  = (r_state != ST_IDLE);
  assign bus.wb_rd_o     = r_wb_rd;
  assign bus.wb_data_o   = (r_state == ST_HOLD)    ? r_skid :
                           (r_state == ST_RD_WAIT) ? bus.mem_data_i : 32'd0;

  assign bus.exc_valid_o = r_exc_valid;
  assign bus.exc_cause_o = r_exc_cause;
  assign bus.exc_addr_o  = r_exc_addr;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural data RAM and wb/exception scoreboards.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(32), .RD_W(5)) bus ();

  lsu_ctrl #(.ADDR_W(32), .RD_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
  typedef struct { logic [1:0] cause; logic [31:0] addr; } exc_t;

  wb_t  wb_q[$];
  exc_t exc_q[$];
  int   wb_cyc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_wb_cyc = -1;
  int   acc_cyc;
  logic        s_we, s_re;
  logic [2:0]  s_size;
  logic [31:0] s_addr, s_data;
  logic [31:0] ram [0:255];

  function automatic logic [31:0] ram_rd(input logic [31:0] wv, input logic [2:0] sz, input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = wv[8*int'(lo) +: 8];
    h = wv[16*int'(lo[1]) +: 16];
    case (sz)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b011:  return {24'd0, b};
      3'b100:  return {16'd0, h};
      default: return wv;
    endcase
  endfunction

  function automatic logic [31:0] ram_wr(input logic [31:0] wv, input logic [31:0] d, input logic [2:0] sz, input logic [1:0] lo);
    logic [31:0] r;
    r = wv;
    case (sz)
      3'b000:  r[8*int'(lo) +: 8] = d[7:0];
      3'b001:  r[16*int'(lo[1]) +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // RAM: sync write, 1-cycle sync read; output is garbage when no read was issued.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
    end else if (bus.mem_we_o) begin
      ram[bus.mem_addr_o[9:2]] <= ram_wr(ram[bus.mem_addr_o[9:2]], bus.mem_data_o, bus.mem_size_o, bus.mem_addr_o[1:0]);
    end
    if (bus.mem_re_o) bus.mem_data_i <= ram_rd(ram[bus.mem_addr_o[9:2]], bus.mem_size_o, bus.mem_addr_o[1:0]);
    else              bus.mem_data_i <= 32'hBAD0_0000 ^ 32'(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop for writebacks and exception pulses.
  always @(negedge clk) begin
    if (!rst) begin
      check("mem_we_re_excl", 32'(bus.mem_we_o & bus.mem_re_o), 32'd0);
      if (bus.wb_valid_o && bus.wb_ready_i) begin
        check("wb_expected", 32'(wb_q.size() != 0), 32'd1);
        if (wb_q.size() != 0) begin
          wb_t e;
          e = wb_q.pop_front();
          check("wb_rd", 32'(bus.wb_rd_o), 32'(e.rd));
          check("wb_data", bus.wb_data_o, e.data);
        end
        last_wb_cyc = cyc;
        wb_cyc_q.push_back(cyc);
      end
      if (bus.exc_valid_o) begin
        check("exc_expected", 32'(exc_q.size() != 0), 32'd1);
        if (exc_q.size() != 0) begin
          exc_t x;
          x = exc_q.pop_front();
          check("exc_cause", 32'(bus.exc_cause_o), 32'(x.cause));
          check("exc_addr", bus.exc_addr_o, x.addr);
        end
      end
    end
  end

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] d);
    wb_t e;
    e.rd = rd; e.data = d;
    wb_q.push_back(e);
  endtask

  task automatic push_exc(input logic [1:0] c, input logic [31:0] a);
    exc_t x;
    x.cause = c; x.addr = a;
    exc_q.push_back(x);
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, output int waits);
    int n;
    bit got;
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_funct3_i = f3;
    bus.req_addr_i = addr; bus.req_wdata_i = wd; bus.req_rd_i = rd;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (bus.req_ready_o) begin
        got = 1'b1;
        s_we = bus.mem_we_o; s_re = bus.mem_re_o; s_size = bus.mem_size_o;
        s_addr = bus.mem_addr_o; s_data = bus.mem_data_o;
        acc_cyc = cyc + 1;
      end else begin
        n++;
      end
    end
    if (!got) check("req_timeout", 32'd0, 32'd1);
    else      @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    waits = n;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'b000;
    bus.req_addr_i = 32'd0; bus.req_wdata_i = 32'd0; bus.req_rd_i = 5'd0;
    bus.wb_ready_i = 1'b1; bus.mem_data_i = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check("rst_exc_valid", 32'(bus.exc_valid_o), 32'd0);
    check("rst_exc_cause", 32'(bus.exc_cause_o), 32'd0);
    check("rst_exc_addr", bus.exc_addr_o, 32'd0);
    check("rst_wb_rd", 32'(bus.wb_rd_o), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    check("rst_mem_idle", {bus.mem_addr_o[29:0], bus.mem_we_o, bus.mem_re_o}, 32'd0);
    @(posedge clk); #1;

    // 1: SW then LW, latency check
    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, w);
    check("t1_sw_we", 32'(s_we), 32'd1);
    check("t1_sw_re", 32'(s_re), 32'd0);
    check("t1_sw_size", 32'(s_size), 32'd2);
    check("t1_sw_data", s_data, 32'hDEADBEEF);
    check("t1_sw_addr", s_addr, 32'h100);
    push_wb(5'd1, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h100, 32'd0, 5'd1, w);
    n = acc_cyc;
    idle(3);
    check("t1_wb_latency", 32'(last_wb_cyc), 32'(n));

    // 2: byte store and sign/zero-extended loads
    do_req(1'b1, 3'b000, 32'h103, 32'h00000080, 5'd0, w);
    check("t2_sb_size", 32'(s_size), 32'd0);
    check("t2_sb_addr", s_addr, 32'h103);
    push_wb(5'd2, 32'hFFFFFF80);
    do_req(1'b0, 3'b000, 32'h103, 32'd0, 5'd2, w);
    push_wb(5'd3, 32'h00000080);
    do_req(1'b0, 3'b100, 32'h103, 32'd0, 5'd3, w);
    check("t2_lbu_size", 32'(s_size), 32'd3);
    push_wb(5'd4, 32'h000080AD);
    do_req(1'b0, 3'b101, 32'h102, 32'd0, 5'd4, w);
    check("t2_lhu_size", 32'(s_size), 32'd4);
    push_wb(5'd5, 32'hFFFF80AD);
    do_req(1'b0, 3'b001, 32'h102, 32'd0, 5'd5, w);
    idle(2);

    // 3: back-to-back loads at full rate
    do_req(1'b1, 3'b010, 32'h0, 32'h11111111, 5'd0, w);
    do_req(1'b1, 3'b010, 32'h4, 32'h22222222, 5'd0, w);
    do_req(1'b1, 3'b010, 32'h8, 32'h33333333, 5'd0, w);
    push_wb(5'd6, 32'h11111111);
    do_req(1'b0, 3'b010, 32'h0, 32'd0, 5'd6, w);
    push_wb(5'd7, 32'h22222222);
    do_req(1'b0, 3'b010, 32'h4, 32'd0, 5'd7, w);
    check("t3_ready_held_2", 32'(w), 32'd0);
    push_wb(5'd8, 32'h33333333);
    do_req(1'b0, 3'b010, 32'h8, 32'd0, 5'd8, w);
    check("t3_ready_held_3", 32'(w), 32'd0);
    idle(3);
    n = wb_cyc_q.size();
    check("t3_wb_count", 32'(n >= 3), 32'd1);
    if (n >= 3) begin
      check("t3_consec_a", 32'(wb_cyc_q[n-2] - wb_cyc_q[n-3]), 32'd1);
      check("t3_consec_b", 32'(wb_cyc_q[n-1] - wb_cyc_q[n-2]), 32'd1);
    end

    // 4: writeback backpressure -> HOLD
    bus.wb_ready_i = 1'b0;
    push_wb(5'd9, 32'h22222222);
    do_req(1'b0, 3'b010, 32'h4, 32'd0, 5'd9, w);
    repeat (3) begin
      @(negedge clk);
      check("t4_wb_valid", 32'(bus.wb_valid_o), 32'd1);
      check("t4_req_ready", 32'(bus.req_ready_o), 32'd0);
      check("t4_wb_data", bus.wb_data_o, 32'h22222222);
      check("t4_wb_rd", 32'(bus.wb_rd_o), 32'd9);
    end
    @(posedge clk); #1;
    bus.wb_ready_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_idle_valid", 32'(bus.wb_valid_o), 32'd0);
    check("t4_idle_ready", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk); #1;

    // 5: misalignment and illegal funct3
`ifdef LSU_MISALIGN_TRAP_EN
    push_exc(2'b01, 32'h102);
    do_req(1'b0, 3'b010, 32'h102, 32'd0, 5'd10, w);
    check("t5_mis_no_re", 32'(s_re), 32'd0);
    idle(2);
    push_exc(2'b10, 32'h201);
    do_req(1'b1, 3'b001, 32'h201, 32'h0000A5A5, 5'd0, w);
    check("t5_mis_no_we", 32'(s_we), 32'd0);
    idle(2);
    push_wb(5'd11, 32'h00000000);
`else
    push_wb(5'd10, 32'h80ADBEEF);
    do_req(1'b0, 3'b010, 32'h102, 32'd0, 5'd10, w);
    check("t5_align_addr", s_addr, 32'h100);
    check("t5_align_re", 32'(s_re), 32'd1);
    idle(2);
    do_req(1'b1, 3'b001, 32'h201, 32'h0000A5A5, 5'd0, w);
    check("t5_align_st_addr", s_addr, 32'h200);
    check("t5_align_we", 32'(s_we), 32'd1);
    idle(2);
    push_wb(5'd11, 32'h0000A5A5);
`endif
    do_req(1'b0, 3'b101, 32'h200, 32'd0, 5'd11, w);
    idle(2);
    push_exc(2'b11, 32'h40);
    do_req(1'b0, 3'b011, 32'h40, 32'd0, 5'd12, w);
    check("t5_ill_ld_mem", {30'd0, s_we, s_re}, 32'd0);
    idle(2);
    push_exc(2'b11, 32'h44);
    do_req(1'b1, 3'b100, 32'h44, 32'h12345678, 5'd0, w);
    check("t5_ill_st_mem", {30'd0, s_we, s_re}, 32'd0);
    idle(2);
    push_wb(5'd12, 32'h80ADBEEF);
    do_req(1'b0, 3'b010, 32'h100, 32'd0, 5'd12, w);
    push_exc(2'b11, 32'h48);
    do_req(1'b0, 3'b011, 32'h48, 32'd0, 5'd13, w);
    check("t5_retire_fault_accept", 32'(w), 32'd0);
    idle(3);

    // 6: reset while a load is in flight drops it
    do_req(1'b0, 3'b010, 32'h0, 32'd0, 5'd14, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    check("t6_req_ready", 32'(bus.req_ready_o), 32'd1);
    check("t6_wb_rd", 32'(bus.wb_rd_o), 32'd0);
    idle(4);

    check("end_wb_q_empty", 32'(wb_q.size()), 32'd0);
    check("end_exc_q_empty", 32'(exc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
